// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// Controller (state + iteration counter) and datapath (A/Q/M + trial subtractor) share this module.
module seq_divider #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  busy,
  output logic                  done,
  output logic                  dbz
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]            state;
  logic [DATA_WIDTH:0]   regA;
  logic [DATA_WIDTH-1:0] regQ;
  logic [DATA_WIDTH-1:0] regM;
  logic [CNT_WIDTH-1:0]  cnt;

  logic [DATA_WIDTH:0]   shiftA;
  logic [DATA_WIDTH:0]   trialDiff;
  logic                  trialOk;

  // NOTE: combinational logic assigns every output unconditionally so no latch is inferred.
  always_comb begin
    shiftA    = {regA[DATA_WIDTH-1:0], regQ[DATA_WIDTH-1]};
    trialDiff = shiftA - {1'b0, regM};
    trialOk   = ~trialDiff[DATA_WIDTH];
  end

  // A's top bit only exists to hold the trial-subtract sign; after a restore it is always 0.
  logic unusedTopA;
  assign unusedTopA = regA[DATA_WIDTH];

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= IDLE;
      regA      <= '0;
      regQ      <= '0;
      regM      <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dbz       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            regM  <= divisor;
            regQ  <= dividend;
            regA  <= '0;
            cnt   <= CNT_WIDTH'(DATA_WIDTH);
            dbz   <= 1'b0;
            busy  <= 1'b1;
            state <= (divisor != '0) ? CALC : DONE;
          end
        end

        CALC: begin
          regA <= trialOk ? trialDiff : shiftA;
          regQ <= {regQ[DATA_WIDTH-2:0], trialOk};
          cnt  <= cnt - 1'b1;
          if (cnt == CNT_WIDTH'(1)) state <= DONE;
        end

        DONE: begin
          // A zero divisor skipped CALC, so Q still holds the captured dividend.
          if (regM == '0) begin
            quotient  <= '1;
            remainder <= regQ;
            dbz       <= 1'b1;
          end else begin
            quotient  <= regQ;
            remainder <= regA[DATA_WIDTH-1:0];
            dbz       <= 1'b0;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed table, multi-cycle corner sequences, random sweep.
module tb_seq_divider;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         clear;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         dbz;

  int checks = 0;
  int errors = 0;

  seq_divider #(.DATA_WIDTH(W)) dut (
    .clk(clk), .clear(clear), .start(start),
    .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder),
    .busy(busy), .done(done), .dbz(dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] dd;
    logic [W-1:0] dv;
    logic [W-1:0] expQ;
    logic [W-1:0] expR;
    logic         expZ;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model straight from the arithmetic definition.
  task automatic refDiv(input logic [W-1:0] dd, input logic [W-1:0] dv,
                        output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    if (dv == 0) begin
      q = '1; r = dd; z = 1'b1;
    end else begin
      q = dd / dv; r = dd % dv; z = 1'b0;
    end
  endtask

  // Called #1 after an edge; start is seen at the next edge (edge 0).
  task automatic runOp(input logic [W-1:0] dd, input logic [W-1:0] dv,
                       output int lat, output int busyCnt);
    start = 1'b1; dividend = dd; divisor = dv;
    @(posedge clk); #1;
    start = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    lat = 0;
    busyCnt = busy ? 1 : 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busyCnt++;
    end
  endtask

  task automatic checkOp(input string name, input logic [W-1:0] dd, input logic [W-1:0] dv,
                         input logic [W-1:0] expQ, input logic [W-1:0] expR, input logic expZ,
                         input bit checkTiming);
    int lat, busyCnt;
    runOp(dd, dv, lat, busyCnt);
    check({name, " done"}, 32'(done), 32'd1);
    check({name, " quotient"}, 32'(quotient), 32'(expQ));
    check({name, " remainder"}, 32'(remainder), 32'(expR));
    check({name, " dbz"}, 32'(dbz), 32'(expZ));
    if (checkTiming) begin
      check({name, " latency"}, 32'(lat), expZ ? 32'd1 : 32'(W + 1));
      check({name, " busy cycles"}, 32'(busyCnt), expZ ? 32'd1 : 32'(W + 1));
    end
  endtask

  vec_t vecs[$];

  initial begin
    logic [W-1:0] q, r, dd, dv, heldQ, heldR;
    logic z;
    int lat;

    clear = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1 clear = 1'b0;
    check("reset quotient", 32'(quotient), 32'd0);
    check("reset remainder", 32'(remainder), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset dbz", 32'(dbz), 32'd0);

    vecs.push_back('{16'd100,   16'd7,      16'd14,     16'd2,      1'b0});
    vecs.push_back('{16'hFFFF,  16'd1,      16'hFFFF,   16'd0,      1'b0});
    vecs.push_back('{16'hFFFF,  16'hFFFF,   16'd1,      16'd0,      1'b0});
    vecs.push_back('{16'd5,     16'd9,      16'd0,      16'd5,      1'b0});
    vecs.push_back('{16'd0,     16'd3,      16'd0,      16'd0,      1'b0});
    vecs.push_back('{16'h1234,  16'd0,      16'hFFFF,   16'h1234,   1'b1});
    vecs.push_back('{16'd1000,  16'd3,      16'd333,    16'd1,      1'b0});
    vecs.push_back('{16'd12345, 16'd1000,   16'd12,     16'd345,    1'b0});

    foreach (vecs[i]) begin
      checkOp($sformatf("vec%0d", i), vecs[i].dd, vecs[i].dv,
              vecs[i].expQ, vecs[i].expR, vecs[i].expZ, 1'b1);
      heldQ = quotient; heldR = remainder;
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("vec%0d done pulse", i), 32'(done), 32'd0);
      check($sformatf("vec%0d held quotient", i), 32'(quotient), 32'(vecs[i].expQ));
      check($sformatf("vec%0d held remainder", i), 32'(remainder), 32'(vecs[i].expR));
    end

    // Clear during iteration 8 discards everything.
    start = 1'b1; dividend = 16'd1000; divisor = 16'd3;
    @(posedge clk); #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    check("midclear quotient", 32'(quotient), 32'd0);
    check("midclear remainder", 32'(remainder), 32'd0);
    check("midclear busy", 32'(busy), 32'd0);
    check("midclear done", 32'(done), 32'd0);
    check("midclear dbz", 32'(dbz), 32'd0);
    repeat (2) @(posedge clk);
    #1 check("midclear stays idle", 32'({busy, done}), 32'd0);

    checkOp("after clear", 16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 1'b1);

    // A start pulse during CALC must not re-capture operands.
    start = 1'b1; dividend = 16'd1000; divisor = 16'd3;
    @(posedge clk); #1 start = 1'b0;
    lat = 0;
    repeat (4) begin @(posedge clk); lat++; end
    #1 start = 1'b1; dividend = 16'd50; divisor = 16'd5;
    @(posedge clk); #1 start = 1'b0; lat++;
    while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
    check("ignored start latency", 32'(lat), 32'(W + 1));
    check("ignored start quotient", 32'(quotient), 32'd333);
    check("ignored start remainder", 32'(remainder), 32'd1);

    // Back-to-back: runOp is entered during the done cycle of the previous op.
    checkOp("b2b first", 16'h1234, 16'd0, 16'hFFFF, 16'h1234, 1'b1, 1'b1);
    checkOp("b2b second", 16'd65535, 16'd256, 16'd255, 16'd255, 1'b0, 1'b1);
    checkOp("b2b third", 16'd7, 16'd2, 16'd3, 16'd1, 1'b0, 1'b1);

    for (int n = 0; n < 1000; n++) begin
      dd = W'($urandom);
      case ($urandom_range(0, 9))
        0:       dv = '0;
        1:       dv = 16'd1;
        2:       dv = W'($urandom_range(2, 15));
        3:       dv = dd;
        default: dv = W'($urandom);
      endcase
      refDiv(dd, dv, q, r, z);
      checkOp($sformatf("rand%0d %0d/%0d", n, dd, dv), dd, dv, q, r, z, n < 20);
      if (dv != 0) begin
        check($sformatf("rand%0d invariant", n),
              32'(quotient) * 32'(dv) + 32'(remainder), 32'(dd));
        check($sformatf("rand%0d rem<div", n), 32'(remainder < dv), 32'd1);
      end
      if (n % 7 == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
